// File: rtl/trap_redirect_ctrl_pkg.sv
// Shared constants for the machine-mode trap/return controller: CSR addresses,
// cause codes, mstatus bit positions and the redirect FSM state encoding.
package trap_redirect_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int CAUSE_ILLEGAL = 2;
  localparam int CAUSE_ECALL_M = 11;
  localparam int IRQ_SW        = 3;
  localparam int IRQ_TIMER     = 7;
  localparam int IRQ_EXT       = 11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/trap_redirect_ctrl_csr.sv
// Machine-mode CSR storage (mstatus, mie, mtvec, mepc, mcause) with read mux and
// trap/mret-vs-software-write arbitration. TRAP_VECTORED_EN keeps mtvec[1:0].
module trap_csr_file
  import trap_redirect_ctrl_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  MTVEC_RESET = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_en,
  output logic [XLEN-1:0] csr_rdata,
  output logic            mstatus_mie,
  output logic            mie_ext,
  output logic            mie_sw,
  output logic            mie_timer,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  logic            mie_q, mpie_q;
  logic            mie_ext_q, mie_sw_q, mie_timer_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q;
  logic            wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

  function automatic logic [XLEN-1:0] mtvec_legal(input logic [XLEN-1:0] v);
`ifdef TRAP_VECTORED_EN
    return v;
`else
    return v & ~XLEN'(3);
`endif
  endfunction

  assign wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
  assign wr_mie     = csr_we && (csr_addr == CSR_MIE);
  assign wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
  assign wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
  assign wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE);

  // Trap/mret side effects override a same-cycle software write to the same CSR.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mie_ext_q   <= 1'b0;
      mie_sw_q    <= 1'b0;
      mie_timer_q <= 1'b0;
      mtvec_q     <= mtvec_legal(MTVEC_RESET);
      mepc_q      <= '0;
      mcause_q    <= '0;
    end else begin
      if (trap_en) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (mret_en) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr_mstatus) begin
        mie_q  <= csr_wdata[MSTATUS_MIE];
        mpie_q <= csr_wdata[MSTATUS_MPIE];
      end
      if (wr_mie) begin
        mie_ext_q   <= csr_wdata[IRQ_EXT];
        mie_sw_q    <= csr_wdata[IRQ_SW];
        mie_timer_q <= csr_wdata[IRQ_TIMER];
      end
      if (wr_mtvec) mtvec_q <= mtvec_legal(csr_wdata);
      if (trap_en)      mepc_q <= trap_pc & ~XLEN'(3);
      else if (wr_mepc) mepc_q <= csr_wdata;
      if (trap_en)        mcause_q <= trap_cause;
      else if (wr_mcause) mcause_q <= csr_wdata;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = mie_q;
        csr_rdata[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MIE: begin
        csr_rdata[IRQ_EXT]   = mie_ext_q;
        csr_rdata[IRQ_SW]    = mie_sw_q;
        csr_rdata[IRQ_TIMER] = mie_timer_q;
      end
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      default:    csr_rdata = '0;
    endcase
  end

  assign mstatus_mie = mie_q;
  assign mie_ext     = mie_ext_q;
  assign mie_sw      = mie_sw_q;
  assign mie_timer   = mie_timer_q;
  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;

endmodule

// File: rtl/trap_redirect_ctrl.sv
// Machine-mode trap/return controller: event arbitration in M, flush/redirect FSM
// feeding PC-select. Vectored interrupts follow TRAP_VECTORED_EN via mtvec[1:0].
module trap_redirect_ctrl
  import trap_redirect_ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0100,
  parameter int              DRAIN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_m,
  input  logic [XLEN-1:0] pc_m,
  input  logic            ecall_m,
  input  logic            illegal_m,
  input  logic            mret_m,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            stall_f,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_taken,
  output logic            mret_taken
);

  state_e          state, state_next;
  logic [1:0]      drain_cnt;
  logic            mstatus_mie, mie_ext, mie_sw, mie_timer;
  logic [XLEN-1:0] mtvec, mepc;
  logic            ext_pend, sw_pend, timer_pend, irq_pending;
  logic [4:0]      irq_code;
  logic            can_eval, exc, trap_en, mret_en;
  logic [XLEN-1:0] trap_cause;
  logic            is_mret_q, is_irq_q;
  logic [4:0]      code_q;

  trap_csr_file #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .trap_en     (trap_en),
    .trap_cause  (trap_cause),
    .trap_pc     (pc_m),
    .mret_en     (mret_en),
    .csr_rdata   (csr_rdata),
    .mstatus_mie (mstatus_mie),
    .mie_ext     (mie_ext),
    .mie_sw      (mie_sw),
    .mie_timer   (mie_timer),
    .mtvec       (mtvec),
    .mepc        (mepc)
  );

  // mtvec[1:0] can only be 2'b01 when the vectored build keeps those bits.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic            irq,
                                                  input logic [4:0]      code);
    logic [XLEN-1:0] base;
    logic            vec;
    base = tvec & ~XLEN'(3);
    vec  = (tvec[1:0] == 2'b01) && irq;
    return base + (vec ? XLEN'({code, 2'b00}) : '0);
  endfunction

  assign ext_pend    = irq_ext & mie_ext;
  assign sw_pend     = irq_sw & mie_sw;
  assign timer_pend  = irq_timer & mie_timer;
  assign irq_pending = mstatus_mie & (ext_pend | sw_pend | timer_pend);
  assign irq_code    = ext_pend ? 5'(IRQ_EXT) : (sw_pend ? 5'(IRQ_SW) : 5'(IRQ_TIMER));

  // Priority: illegal > ecall > mret > interrupt; only sampled in IDLE.
  assign can_eval = (state == S_IDLE) && valid_m && !rst;
  assign exc      = illegal_m | ecall_m;
  assign trap_en  = can_eval && (exc || (!mret_m && irq_pending));
  assign mret_en  = can_eval && !exc && mret_m;

  always_comb begin
    trap_cause = '0;
    if (illegal_m)    trap_cause = XLEN'(CAUSE_ILLEGAL);
    else if (ecall_m) trap_cause = XLEN'(CAUSE_ECALL_M);
    else              trap_cause = {1'b1, {(XLEN-6){1'b0}}, irq_code};
  end

  assign trap_taken = trap_en;
  assign mret_taken = mret_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      redirect_pc <= '0;
      is_mret_q   <= 1'b0;
      is_irq_q    <= 1'b0;
      code_q      <= '0;
    end else begin
      state <= state_next;
      if (trap_en || mret_en) begin
        is_mret_q <= mret_en;
        is_irq_q  <= trap_en && !exc;
        code_q    <= trap_cause[4:0];
      end
      if (state == S_FLUSH)
        redirect_pc <= is_mret_q ? mepc : trap_target(mtvec, is_irq_q, code_q);
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_next     = state;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (trap_en || mret_en) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        flush      = 1'b1;
        state_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush = 1'b1;
        if (!stall_f) begin
          redirect_valid = 1'b1;
          state_next     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// Directed, table-driven bench for trap_redirect_ctrl plus hand-written sequences
// for stall, mret-vs-interrupt ordering, CSR-write collision and mid-flight reset.
module tb_trap_redirect_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] TIMER_TGT = 32'h0000_021C;
  localparam logic [31:0] SW_TGT    = 32'h0000_030C;
  localparam bit          VEC_EN    = 1'b1;
`else
  localparam logic [31:0] TIMER_TGT = 32'h0000_0200;
  localparam logic [31:0] SW_TGT    = 32'h0000_0300;
  localparam bit          VEC_EN    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_m = 1'b0;
  logic [31:0] pc_m = '0;
  logic        ecall_m = 1'b0, illegal_m = 1'b0, mret_m = 1'b0;
  logic        irq_ext = 1'b0, irq_sw = 1'b0, irq_timer = 1'b0;
  logic        stall_f = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        flush, redirect_valid, trap_taken, mret_taken;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  trap_redirect_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .valid_m        (valid_m),
    .pc_m           (pc_m),
    .ecall_m        (ecall_m),
    .illegal_m      (illegal_m),
    .mret_m         (mret_m),
    .irq_ext        (irq_ext),
    .irq_sw         (irq_sw),
    .irq_timer      (irq_timer),
    .stall_f        (stall_f),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_taken     (trap_taken),
    .mret_taken     (mret_taken)
  );

  always #5 clk = ~clk;

  // flags = {illegal, ecall, mret, ext, sw, timer}; kind 0=none, 1=trap, 2=mret
  typedef struct packed {
    logic [31:0] mstatus_w;
    logic [31:0] mie_w;
    logic [31:0] mtvec_w;
    logic [31:0] mepc_w;
    logic [5:0]  flags;
    logic [31:0] pc;
    logic [1:0]  kind;
    logic [31:0] exp_pc;
    logic [31:0] exp_mcause;
    logic [31:0] exp_mepc;
    logic [31:0] exp_mstatus;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic clear_events();
    valid_m = 1'b0; illegal_m = 1'b0; ecall_m = 1'b0; mret_m = 1'b0;
    irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h0,  32'h0,   32'h200, 32'h0,  6'b100000, 32'h40, 2'd1, 32'h200,     32'h2,         32'h40, 32'h00};
    vecs[1]  = '{32'h8,  32'h80,  32'h201, 32'h0,  6'b000001, 32'h84, 2'd1, TIMER_TGT,   32'h8000_0007, 32'h84, 32'h80};
    vecs[2]  = '{32'h80, 32'h0,   32'h100, 32'h84, 6'b001000, 32'h50, 2'd2, 32'h84,      32'h0,         32'h84, 32'h88};
    vecs[3]  = '{32'h8,  32'h0,   32'h100, 32'h0,  6'b010000, 32'h13, 2'd1, 32'h100,     32'hB,         32'h10, 32'h80};
    vecs[4]  = '{32'h8,  32'h888, 32'h100, 32'h0,  6'b000111, 32'h20, 2'd1, 32'h100,     32'h8000_000B, 32'h20, 32'h80};
    vecs[5]  = '{32'h8,  32'h888, 32'h301, 32'h0,  6'b000011, 32'h24, 2'd1, SW_TGT,      32'h8000_0003, 32'h24, 32'h80};
    vecs[6]  = '{32'h88, 32'h0,   32'h100, 32'h44, 6'b111000, 32'h28, 2'd1, 32'h100,     32'h2,         32'h28, 32'h80};
    vecs[7]  = '{32'h0,  32'h888, 32'h100, 32'h0,  6'b000101, 32'h30, 2'd0, 32'h0,       32'h0,         32'h0,  32'h00};
    vecs[8]  = '{32'h8,  32'h80,  32'h100, 32'h0,  6'b000100, 32'h34, 2'd0, 32'h0,       32'h0,         32'h0,  32'h08};
    vecs[9]  = '{32'h0,  32'h0,   32'h204, 32'h0,  6'b011000, 32'h60, 2'd1, 32'h204,     32'hB,         32'h60, 32'h00};
    vecs[10] = '{32'h0,  32'h0,   32'h201, 32'h0,  6'b100000, 32'h64, 2'd1, 32'h200,     32'h2,         32'h64, 32'h00};

    // Reset state
    tick();
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_trap_taken", {31'b0, trap_taken}, 32'h0);
    chk("rst_mret_taken", {31'b0, mret_taken}, 32'h0);
    rst = 1'b0;
    rd("rst_mtvec", A_MTVEC, 32'h100);
    rd("rst_mstatus", A_MSTATUS, 32'h0);
    rd("rst_mepc", A_MEPC, 32'h0);
    rd("rst_mcause", A_MCAUSE, 32'h0);
    rd("unmapped_csr", 12'h123, 32'h0);

    for (int i = 0; i < 11; i++) begin
      vec_t v;
      v = vecs[i];
      do_reset();
      wr(A_MTVEC, v.mtvec_w);
      wr(A_MIE, v.mie_w);
      wr(A_MSTATUS, v.mstatus_w);
      wr(A_MEPC, v.mepc_w);
      rd($sformatf("v%0d_mtvec_rb", i), A_MTVEC, VEC_EN ? v.mtvec_w : (v.mtvec_w & ~32'h3));
      valid_m = 1'b1; pc_m = v.pc;
      {illegal_m, ecall_m, mret_m, irq_ext, irq_sw, irq_timer} = v.flags;
      #1;
      chk($sformatf("v%0d_trap_taken", i), {31'b0, trap_taken}, {31'b0, v.kind == 2'd1});
      chk($sformatf("v%0d_mret_taken", i), {31'b0, mret_taken}, {31'b0, v.kind == 2'd2});
      tick();
      clear_events();
      chk($sformatf("v%0d_flush_n1", i), {31'b0, flush}, {31'b0, v.kind != 2'd0});
      rd($sformatf("v%0d_mstatus", i), A_MSTATUS, v.exp_mstatus);
      rd($sformatf("v%0d_mepc", i), A_MEPC, v.exp_mepc);
      rd($sformatf("v%0d_mcause", i), A_MCAUSE, v.exp_mcause);
      if (v.kind != 2'd0) begin
        chk($sformatf("v%0d_rv_n1", i), {31'b0, redirect_valid}, 32'h0);
        tick();
        chk($sformatf("v%0d_flush_n2", i), {31'b0, flush}, 32'h1);
        chk($sformatf("v%0d_rv_n2", i), {31'b0, redirect_valid}, 32'h1);
        chk($sformatf("v%0d_redirect_pc", i), redirect_pc, v.exp_pc);
        tick();
        chk($sformatf("v%0d_flush_n3", i), {31'b0, flush}, 32'h0);
        chk($sformatf("v%0d_rv_n3", i), {31'b0, redirect_valid}, 32'h0);
      end
    end

    // REDIRECT held by fetch stall, then a single redirect pulse
    do_reset();
    valid_m = 1'b1; illegal_m = 1'b1; pc_m = 32'h40;
    tick();
    clear_events();
    stall_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d_flush", c), {31'b0, flush}, 32'h1);
      chk($sformatf("stall%0d_rv", c), {31'b0, redirect_valid}, 32'h0);
    end
    stall_f = 1'b0;
    #1;
    chk("stall_release_rv", {31'b0, redirect_valid}, 32'h1);
    chk("stall_release_pc", redirect_pc, 32'h100);
    tick();
    chk("stall_after_rv", {31'b0, redirect_valid}, 32'h0);
    chk("stall_after_flush", {31'b0, flush}, 32'h0);

    // mret wins over a same-cycle interrupt; interrupt taken once back in IDLE
    do_reset();
    wr(A_MSTATUS, 32'h88);
    wr(A_MIE, 32'h800);
    wr(A_MEPC, 32'h84);
    valid_m = 1'b1; mret_m = 1'b1; irq_ext = 1'b1; pc_m = 32'h70;
    #1;
    chk("mi_mret_taken", {31'b0, mret_taken}, 32'h1);
    chk("mi_trap_n0", {31'b0, trap_taken}, 32'h0);
    tick();
    mret_m = 1'b0;
    #1;
    chk("mi_trap_flush", {31'b0, trap_taken}, 32'h0);
    tick();
    chk("mi_rv", {31'b0, redirect_valid}, 32'h1);
    chk("mi_redirect_pc", redirect_pc, 32'h84);
    chk("mi_trap_redirect", {31'b0, trap_taken}, 32'h0);
    tick();
    chk("mi_trap_drain", {31'b0, trap_taken}, 32'h0);
    chk("mi_drain_flush", {31'b0, flush}, 32'h0);
    tick();
    chk("mi_trap_idle", {31'b0, trap_taken}, 32'h1);
    tick();
    clear_events();
    rd("mi_mcause", A_MCAUSE, 32'h8000_000B);
    rd("mi_mepc", A_MEPC, 32'h70);
    rd("mi_mstatus", A_MSTATUS, 32'h80);

    // CSR write to mepc collides with ecall; then reset during FLUSH
    do_reset();
    wr(A_MTVEC, 32'h300);
    valid_m = 1'b1; ecall_m = 1'b1; pc_m = 32'h10;
    csr_we = 1'b1; csr_addr = A_MEPC; csr_wdata = 32'h999;
    tick();
    clear_events();
    csr_we = 1'b0;
    rd("col_mepc", A_MEPC, 32'h10);
    rd("col_mcause", A_MCAUSE, 32'hB);
    chk("col_flush", {31'b0, flush}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstf_flush", {31'b0, flush}, 32'h0);
    chk("rstf_rv", {31'b0, redirect_valid}, 32'h0);
    rd("rstf_mtvec", A_MTVEC, 32'h100);
    rd("rstf_mepc", A_MEPC, 32'h0);
    tick();
    chk("rstf_idle_flush", {31'b0, flush}, 32'h0);
    chk("rstf_idle_rv", {31'b0, redirect_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
